// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_fa.sv
// Gate-level full-adder cell: the one sum/carry slice reused every bit-time.
module serial_subtractor_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic cout_o
);

    logic ab_x;
    logic ab_a;
    logic cx_a;

    // Classic two half-adders plus an OR for the carry.
    assign ab_x   = a_i ^ b_i;
    assign ab_a   = a_i & b_i;
    assign cx_a   = ab_x & c_i;
    assign sum_o  = ab_x ^ c_i;
    assign cout_o = ab_a | cx_a;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, computed as a + ~b + 1 through one full-adder
// cell and a registered carry. Results are latched as the MSB bit is produced,
// so diff/borrow/overflow are already valid during the done cycle.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q,    ovf_d;

    logic             fa_sum;
    logic             fa_cout;
    logic             load;

    serial_subtractor_fa u_fa (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .c_i    (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    // Next-state, datapath shifts and handshake outputs.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        busy     = 1'b0;
        done     = 1'b0;
        load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load = start;
            end
            ST_RUN: begin
                // start is deliberately ignored here: no restart, no queueing.
                busy    = 1'b1;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                if (cnt_q == '0) begin
                    // MSB cycle: carry_q is the carry into the MSB.
                    state_d  = ST_DONE;
                    diff_d   = {fa_sum, res_q[WIDTH-1:1]};
                    borrow_d = ~fa_cout;
                    ovf_d    = carry_q ^ fa_cout;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
                load    = start;
            end
            default: state_d = ST_IDLE;
        endcase

        // Accepted start: invert b and seed carry=1 to form the two's complement.
        if (load) begin
            state_d = ST_RUN;
            a_sh_d  = a;
            b_sh_d  = ~b;
            carry_d = 1'b1;
            cnt_d   = CNT_LAST;
        end
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;

endmodule
